// File: rtl/hack_mem_pkg.sv
// Purpose: shared constants, region/state enums and address decode for the Hack data memory.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package hack_mem_pkg;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 16;
   localparam int RAM_AW = 14;
   localparam int SCR_AW = 13;

   localparam logic [ADDR_W-1:0] SCREEN_BASE = 15'd16384;
   localparam logic [ADDR_W-1:0] KBD_ADDR    = 15'd24576;

   typedef enum logic [1:0] {RAM, SCREEN, KBD, NONE} region_t;

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} scan_state_t;

   // Hack memory map: RAM below the screen, screen up to the keyboard word, rest unmapped.
   function automatic region_t decode(input logic [ADDR_W-1:0] addr);
      if (addr < SCREEN_BASE)   return RAM;
      else if (addr < KBD_ADDR) return SCREEN;
      else if (addr == KBD_ADDR) return KBD;
      else                      return NONE;
   endfunction

endpackage

// File: rtl/hack_memory_kbd_fifo.sv
// Purpose: small 16-bit FIFO holding key codes until the CPU pops them.
// Latency: a push is visible at head one edge later; a pop advances head at the edge.
// Backpressure: full refuses pushes unless a pop frees the slot in the same cycle.
module kbd_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [15:0]                push_dat,
   input  logic                       pop,
   output logic [15:0]                head,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full
);

   localparam int AW = $clog2(DEPTH);

   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_pop;
   logic          do_push;

   // A pop on an empty FIFO is dropped; a push into a full FIFO is only taken
   // when a real pop frees the head slot at the same edge.
   assign do_pop  = pop && (count != '0);
   assign do_push = push && (!full || do_pop);
   assign full    = (count == (AW+1)'(DEPTH));
   assign head    = (count != '0) ? mem[rd_ptr] : '0;

   // Storage is not reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

   // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/hack_memory.sv
// Purpose: Hack CPU data memory (RAM, screen, keyboard FIFO) plus a screen scan-out engine.
// Latency: inM is combinational; scan words follow scan_start by one edge, one word per cycle.
// Backpressure: none toward the CPU; keyboard side uses kbd_ready, scan-out is free-running.
module hack_memory
   import hack_mem_pkg::*;
#(
   parameter int RAM_WORDS    = 16384,
   parameter int SCREEN_WORDS = 8192,
   parameter int KBD_DEPTH    = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   addressM,
   input  logic [DATA_W-1:0]   outM,
   input  logic                writeM,
   output logic [DATA_W-1:0]   inM,
   input  logic                kbd_valid,
   input  logic [DATA_W-1:0]   kbd_code,
   output logic                kbd_ready,
   input  logic                scan_start,
   output logic                scan_busy,
   output logic                scan_valid,
   output logic [SCR_AW-1:0]   scan_addr,
   output logic [DATA_W-1:0]   scan_word
);

   localparam logic [SCR_AW-1:0] SCAN_LAST = SCR_AW'(SCREEN_WORDS - 1);

   logic [DATA_W-1:0] ram    [RAM_WORDS];
   logic [DATA_W-1:0] screen [SCREEN_WORDS];

   region_t                    region;
   logic [DATA_W-1:0]          kbd_head;
   logic [$clog2(KBD_DEPTH):0] kbd_count;
   logic                       kbd_full;
   logic                       kbd_push;
   logic                       kbd_pop;
   scan_state_t                state;
   logic [SCR_AW-1:0]          scan_idx;

   assign region = decode(addressM);

   // CPU write port into general RAM.
   always_ff @(posedge clk) begin
      if (writeM && region == RAM) ram[addressM[RAM_AW-1:0]] <= outM;
   end

   // CPU write port into the frame buffer; screen offset is the low 13 address bits.
   always_ff @(posedge clk) begin
      if (writeM && region == SCREEN) screen[addressM[SCR_AW-1:0]] <= outM;
   end

   // Zero is the "no key" value at KBD, so it is never queued. A push while
   // full is still taken if the CPU pops in the same cycle.
   assign kbd_push  = kbd_valid && (kbd_code != '0);
   assign kbd_pop   = writeM && (region == KBD) && (kbd_count != '0);
   assign kbd_ready = !kbd_full;

   kbd_fifo #(.DEPTH(KBD_DEPTH)) u_kbd_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (kbd_push),
      .push_dat (kbd_code),
      .pop      (kbd_pop),
      .head     (kbd_head),
      .count    (kbd_count),
      .full     (kbd_full)
   );

   // Zero-latency read mux; writes land at the edge, so same-cycle reads see old data.
   always_comb begin
      inM = '0;
      case (region)
         RAM:     inM = ram[addressM[RAM_AW-1:0]];
         SCREEN:  inM = screen[addressM[SCR_AW-1:0]];
         KBD:     inM = kbd_head;
         default: inM = '0;
      endcase
   end

   // Scan-out FSM; the frame-buffer read is registered, so a CPU write to the
   // same word at the same edge is not seen by the scanner (read-before-write).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         scan_idx   <= '0;
         scan_busy  <= 1'b0;
         scan_valid <= 1'b0;
         scan_addr  <= '0;
         scan_word  <= '0;
      end else begin
         case (state)
            IDLE: begin
               scan_valid <= 1'b0;
               if (scan_start) begin
                  state     <= SCAN;
                  scan_idx  <= '0;
                  scan_busy <= 1'b1;
               end
            end
            SCAN: begin
               scan_word  <= screen[scan_idx];
               scan_addr  <= scan_idx;
               scan_valid <= 1'b1;
               scan_idx   <= scan_idx + 1'b1;
               if (scan_idx == SCAN_LAST) state <= DRAIN;
            end
            DRAIN: begin
               scan_valid <= 1'b0;
               scan_busy  <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hack_memory.sv
module tb_hack_memory;

   logic        clk = 1'b0;
   logic        reset;
   logic [14:0] addressM;
   logic [15:0] outM;
   logic        writeM;
   logic [15:0] inM;
   logic        kbd_valid;
   logic [15:0] kbd_code;
   logic        kbd_ready;
   logic        scan_start;
   logic        scan_busy;
   logic        scan_valid;
   logic [12:0] scan_addr;
   logic [15:0] scan_word;

   typedef struct packed {
      logic [12:0] a;
      logic [15:0] w;
   } exp_t;

   exp_t        sb [$];
   exp_t        e_mon;
   exp_t        e_drv;
   logic [15:0] scr_model [8192];
   logic [15:0] drain_exp [4];

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;
   int n_words    = 0;
   int first_cyc  = 0;
   int last_cyc   = 0;
   int start_cyc  = 0;

   always #5 clk = ~clk;

   hack_memory dut (
      .clk        (clk),
      .reset      (reset),
      .addressM   (addressM),
      .outM       (outM),
      .writeM     (writeM),
      .inM        (inM),
      .kbd_valid  (kbd_valid),
      .kbd_code   (kbd_code),
      .kbd_ready  (kbd_ready),
      .scan_start (scan_start),
      .scan_busy  (scan_busy),
      .scan_valid (scan_valid),
      .scan_addr  (scan_addr),
      .scan_word  (scan_word)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      writeM     = 1'b0;
      kbd_valid  = 1'b0;
      scan_start = 1'b0;
   endtask

   task automatic wr(input logic [14:0] a, input logic [15:0] d);
      addressM = a;
      outM     = d;
      writeM   = 1'b1;
      tick();
   endtask

   task automatic rd(input string tag, input logic [14:0] a, input logic [15:0] exp);
      addressM = a;
      #1;
      check(tag, inM, exp);
   endtask

   task automatic push(input logic [15:0] code);
      kbd_valid = 1'b1;
      kbd_code  = code;
      tick();
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Scan-out monitor: every valid word is matched against the scoreboard head.
   always @(negedge clk) begin
      if (!reset && scan_valid) begin
         if (n_words == 0) first_cyc = cyc;
         last_cyc = cyc;
         n_words++;
         check("scan_pending", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            e_mon = sb.pop_front();
            check("scan_addr", scan_addr, e_mon.a);
            check("scan_word", scan_word, e_mon.w);
         end
      end
   end

   initial begin
      drain_exp  = '{16'd68, 16'd69, 16'd70, 16'd0};
      reset      = 1'b1;
      addressM   = '0;
      outM       = '0;
      writeM     = 1'b0;
      kbd_valid  = 1'b0;
      kbd_code   = '0;
      scan_start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_kbd_ready",  kbd_ready,  1);
      check("rst_scan_busy",  scan_busy,  0);
      check("rst_scan_valid", scan_valid, 0);
      check("rst_scan_addr",  scan_addr,  0);
      check("rst_scan_word",  scan_word,  0);
      reset = 1'b0;
      tick();

      // RAM write/read and same-cycle read-old behaviour
      wr(15'd310, 16'd1000);
      addressM = 15'd310;
      outM     = 16'd1234;
      writeM   = 1'b1;
      #1;
      check("ram_same_cycle", inM, 16'd1000);
      tick();
      rd("ram_after_write", 15'd310, 16'd1234);
      wr(15'd16383, 16'h1357);
      rd("ram_top_word", 15'd16383, 16'h1357);

      // Unmapped region
      wr(15'd30000, 16'h5555);
      rd("unmapped_30000", 15'd30000, 16'h0000);
      rd("unmapped_24577", 15'd24577, 16'h0000);

      // Keyboard FIFO
      rd("kbd_empty", 15'd24576, 16'h0000);
      for (int i = 0; i < 4; i++) push(16'(65 + i));
      check("kbd_full_ready", kbd_ready, 0);
      push(16'd99);
      rd("kbd_head_65", 15'd24576, 16'd65);
      wr(15'd24576, 16'hBEEF);
      rd("kbd_head_66", 15'd24576, 16'd66);
      check("kbd_ready_after_pop", kbd_ready, 1);
      push(16'd69);
      check("kbd_refull_ready", kbd_ready, 0);
      kbd_valid = 1'b1;
      kbd_code  = 16'd70;
      addressM  = 15'd24576;
      writeM    = 1'b1;
      tick();
      rd("kbd_pushpop_full_head", 15'd24576, 16'd67);
      check("kbd_pushpop_full_ready", kbd_ready, 0);
      for (int i = 0; i < 4; i++) begin
         wr(15'd24576, 16'h0000);
         rd("kbd_drain", 15'd24576, drain_exp[i]);
      end
      kbd_valid = 1'b1;
      kbd_code  = 16'd13;
      addressM  = 15'd24576;
      writeM    = 1'b1;
      tick();
      rd("kbd_pushpop_empty", 15'd24576, 16'd13);
      wr(15'd24576, 16'h0000);
      rd("kbd_pop_to_empty", 15'd24576, 16'h0000);
      push(16'd0);
      rd("kbd_zero_dropped", 15'd24576, 16'h0000);

      // Preload the frame buffer: word 0 = 0xFFFF, word k = k otherwise
      for (int k = 0; k < 8192; k++) begin
         scr_model[k] = (k == 0) ? 16'hFFFF : 16'(k);
         wr(15'(16384 + k), scr_model[k]);
      end
      rd("screen_first", 15'd16384, 16'hFFFF);
      rd("screen_last",  15'd24575, 16'd8191);

      // Full frame with a mid-frame collision write and an ignored restart
      for (int k = 0; k < 8192; k++) begin
         e_drv.a = 13'(k);
         e_drv.w = scr_model[k];
         sb.push_back(e_drv);
      end
      n_words    = 0;
      scan_start = 1'b1;
      tick();
      start_cyc = cyc;
      check("scan_busy_at_start",  scan_busy,  1);
      check("scan_valid_at_start", scan_valid, 0);
      repeat (100) tick();
      scan_start = 1'b1;
      wr(15'(16384 + 100), 16'hAAAA);
      scr_model[100] = 16'hAAAA;
      repeat (8091) tick();
      check("scan_busy_last_word", scan_busy, 1);
      tick();
      check("scan_busy_fall",  scan_busy,  0);
      check("scan_valid_fall", scan_valid, 0);
      check("scan_word_count", n_words, 8192);
      check("scan_first_cycle", first_cyc - start_cyc, 1);
      check("scan_contiguous", last_cyc - first_cyc + 1, 8192);
      check("scan_sb_empty", sb.size(), 0);
      rd("screen_collision_commit", 15'(16384 + 100), 16'hAAAA);

      // Reset in the middle of a frame with a full keyboard FIFO
      for (int i = 1; i <= 4; i++) push(16'(i));
      check("kbd_prefill_ready", kbd_ready, 0);
      rd("kbd_prefill_head", 15'd24576, 16'd1);
      for (int k = 0; k <= 4000; k++) begin
         e_drv.a = 13'(k);
         e_drv.w = scr_model[k];
         sb.push_back(e_drv);
      end
      n_words    = 0;
      scan_start = 1'b1;
      tick();
      repeat (4001) tick();
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("rstmid_scan_valid", scan_valid, 0);
      check("rstmid_scan_busy",  scan_busy,  0);
      check("rstmid_scan_addr",  scan_addr,  0);
      check("rstmid_kbd_ready",  kbd_ready,  1);
      rd("rstmid_kbd_empty", 15'd24576, 16'h0000);
      check("rstmid_word_count", n_words, 4001);
      check("rstmid_sb_empty", sb.size(), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (3) tick();
      check("post_rst_scan_idle", scan_busy, 0);
      check("post_rst_valid_idle", scan_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/hack_memory.md
# hack_memory

Data-memory responder for the Hack CPU: answers the CPU's `addressM`/`outM`/`writeM` accesses with `inM` and decodes the Hack memory map into RAM, Screen and Keyboard regions. It also owns two peripheral-facing paths. One is a keyboard input FIFO whose head appears at the keyboard address. The other is a screen scan-out engine that streams the frame buffer to a display without stalling the CPU. It sits directly beside `CPU` in the top-level computer, between the CPU and the display/keyboard front ends.

## Interface
- `RAM_WORDS`, 16384: general RAM depth, addresses 0..16383.
- `SCREEN_WORDS`, 8192: frame buffer depth, addresses 16384..24575.
- `KBD_DEPTH`, 4: keyboard FIFO entries, power of two.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all registers (not RAM/screen contents).
- `addressM`  in  15  CPU data address.
- `outM`  in  16  CPU write data.
- `writeM`  in  1  CPU write strobe, sampled at rising edge.
- `inM`  out  16  read data for `addressM`, combinational.
- `kbd_valid`  in  1  key code offered.
- `kbd_code`  in  16  key code; 0 is never pushed (dropped, `kbd_ready` unaffected).
- `kbd_ready`  out  1  FIFO not full; push when `kbd_valid && kbd_ready`.
- `scan_start`  in  1  single-cycle frame request.
- `scan_busy`  out  1  scan in progress.
- `scan_valid`  out  1  `scan_word` is valid this cycle.
- `scan_addr`  out  13  screen word index of `scan_word`.
- `scan_word`  out  16  frame buffer word.

## Operation
- Decode: 0..16383 is RAM. 16384..24575 is Screen, indexed by `addressM-16384`. 24576 is KBD. 24577..32767 is unmapped.
- Reads: RAM and Screen return the stored word. KBD returns the FIFO head, or 0 when the FIFO is empty. Unmapped addresses return 0.
- Writes: RAM and Screen store `outM`. A write to KBD pops the head; the data is ignored, and a pop on an empty FIFO is a no-op. Unmapped writes are ignored.
- Keyboard FIFO:
  - Push and pop in the same cycle: both take effect and the count is unchanged.
  - Push and pop on an empty FIFO: the push applies and the pop is ignored.
  - `kbd_ready` = count < `KBD_DEPTH`.
- Scanner FSM, IDLE -> SCAN -> DRAIN -> IDLE:
  - IDLE: `scan_start` loads the read index to 0 and moves to SCAN.
  - SCAN: one screen read per cycle, index +1. After index 8191 is issued, move to DRAIN.
  - DRAIN: one cycle to emit the last word, then IDLE.
  - `scan_start` outside IDLE is ignored.
- Read/write collision: a CPU write and a scanner read of the same screen word in the same cycle are read-before-write; the scanner sees the old data.

## Timing
- Reset values: `kbd_ready`=1, `scan_busy`=0, `scan_valid`=0, `scan_addr`=0, `scan_word`=0. FIFO empty, FSM in IDLE.
- `inM` has zero latency from `addressM`. It reflects writes committed at earlier edges; a same-cycle read of a location being written returns the old value.
- A pushed key is visible at KBD on the cycle after the push edge. After a pop edge, the next entry (or 0) is visible.
- Scanner latency:
  - `scan_start` high at edge N: `scan_busy`=1 from N.
  - First `scan_valid` with `scan_addr`=0 after edge N+1.
  - Words 0..8191 on 8192 consecutive cycles, with `scan_valid` contiguous.
  - `scan_busy` falls at the same edge `scan_valid` falls (N+8193).
- `scan_start` on the cycle `scan_busy` falls is accepted; there is one idle cycle between frames.
- Reset mid-scan or mid-FIFO: outputs return to reset values asynchronously, the FIFO is emptied, and the frame is abandoned.

## Structure
- Package `hack_mem_pkg`:
  - `SCREEN_BASE`=16384, `KBD_ADDR`=24576.
  - Region enum {RAM, SCREEN, KBD, NONE}.
  - Scanner state enum {IDLE, SCAN, DRAIN}.
  - Address widths.
- Sub-module `kbd_fifo` (parameter `DEPTH`, 16-bit): push/pop/head/count/full. Decode, memories and scanner stay in `hack_memory`.
- The Screen array has one CPU read/write port and one synchronous scanner read port.

## Test plan
- RAM: write 1234 to address 310 -> `inM`=1234 at 310 on the next cycle; the same-cycle read returns the prior value.
- Map: write 0xFFFF to 16384 -> scan word 0 = 0xFFFF. Write to 30000 -> ignored; reading 30000 returns 0.
- Keyboard:
  - Push 65, 66, 67, 68 -> `kbd_ready`=0 and a fifth push is refused.
  - KBD reads 65; write to 24576 -> KBD reads 66.
  - Push and pop together at count 4 -> count stays 4 and the head advances.
- Empty keyboard: read 24576 -> 0. Pop with a simultaneous push of 13 -> KBD reads 13.
- Scan:
  - Preload screen[k]=k, pulse `scan_start` -> 8192 contiguous valid words with `scan_addr`=k, `scan_word`=k, and `scan_busy` timing as specified.
  - A second `scan_start` mid-frame is ignored.
- Collision and reset: CPU writes 0xAAAA to 16384+100 on the cycle the scanner reads index 100 -> the scanner emits the old word. Assert `reset` at word 4000 -> `scan_valid`/`scan_busy` drop immediately and the FIFO is empty.
